// File: rtl/hyperbus_if.sv
// -----------------------------------------------------------------------------
// hyperbus_if
// Bundles the request-side handshake (hbus_*) and the external HyperBus pins
// (hb_*) served by hyperbus_ctrl.
//   slave  : the controller view (takes requests, drives the HyperBus pins)
//   master : the requester/device view (issues requests, models the device)
// Request side : hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq -> controller
//                hbus_dat_o, hbus_ready, hbus_valid, hbus_busy <- controller
// Device side  : hb_ck_o, hb_cs_n_o, hb_rst_n_o, hb_rwds_o, hb_rwds_oe,
//                hb_dq_o, hb_dq_oe <- controller; hb_rwds_i, hb_dq_i -> controller
// -----------------------------------------------------------------------------
interface hyperbus_if #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16
) ();
    logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i;
    logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
    logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
    logic                       hbus_rrq;
    logic                       hbus_wrq;
    logic                       hbus_ready;
    logic                       hbus_valid;
    logic                       hbus_busy;
    logic                       hb_ck_o;
    logic                       hb_cs_n_o;
    logic                       hb_rst_n_o;
    logic                       hb_rwds_i;
    logic                       hb_rwds_o;
    logic                       hb_rwds_oe;
    logic [7:0]                 hb_dq_i;
    logic [7:0]                 hb_dq_o;
    logic                       hb_dq_oe;

    modport slave (
        input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq, hb_rwds_i, hb_dq_i,
        output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy,
               hb_ck_o, hb_cs_n_o, hb_rst_n_o, hb_rwds_o, hb_rwds_oe, hb_dq_o, hb_dq_oe
    );

    modport master (
        output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq, hb_rwds_i, hb_dq_i,
        input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy,
               hb_ck_o, hb_cs_n_o, hb_rst_n_o, hb_rwds_o, hb_rwds_oe, hb_dq_o, hb_dq_oe
    );
endinterface

// File: rtl/hyperbus_ctrl.sv
// -----------------------------------------------------------------------------
// hyperbus_ctrl
// Single-word HyperBus (HyperRAM) controller. Accepts one read or write request
// from the request FIFO side, issues the 48-bit command/address phase, waits the
// initial latency (doubled when the device holds RWDS high in the first CA
// cycle), moves one 16-bit word and reports completion with a one-cycle
// hbus_ready (write) or hbus_valid (read) pulse in the first recovery cycle.
//
// Ports:
//   hbus_clk  : controller clock, one DQ byte per cycle
//   hbus_rst  : asynchronous active-high reset
//   bus       : hyperbus_if.slave -- request handshake and HyperBus pins
//
// Optional feature: define HBUS_READ_TIMEOUT_EN to abort a read that has not
// delivered its second byte within READ_TIMEOUT RDATA cycles; the read then
// completes with data 16'hFFFF. Without the macro RDATA waits indefinitely.
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module hyperbus_ctrl #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int LATENCY         = 6,
    parameter int CS_HIGH_MIN     = 2,
    parameter int READ_TIMEOUT    = 64
) (
    input  logic      hbus_clk,
    input  logic      hbus_rst,
    hyperbus_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_RECOVER
    } state_t;

    localparam logic [15:0] LAT_LAST_1X = 16'(2 * LATENCY - 1);
    localparam logic [15:0] LAT_LAST_2X = 16'(4 * LATENCY - 1);
    localparam logic [15:0] REC_LAST    = 16'(CS_HIGH_MIN - 1);
`ifdef HBUS_READ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST     = 16'(READ_TIMEOUT - 1);
`endif

    // Command/address word: R/W#, address space (memory), burst type (linear),
    // upper word address, reserved zeros, lower 3 address bits.
    function automatic logic [47:0] ca_word(input logic rd, input logic [31:0] adr);
        return {rd, 1'b0, 1'b1, adr[31:3], 13'd0, adr[2:0]};
    endfunction

    state_t                     r_state;
    logic [15:0]                r_cnt;
    logic [47:0]                r_ca;
    logic                       r_wr;
    logic [HBUS_DATA_WIDTH-1:0] r_wdat;
    logic [HBUS_DATA_WIDTH-1:0] r_rdat;
    logic                       r_lat_dbl;
    logic [7:0]                 r_rbyte;
    logic                       r_got_first;
    logic                       r_rwds_prev;
    logic                       r_ck;
    logic                       r_cs_n;
    logic                       r_rst_n;
    logic [7:0]                 r_dq_o;
    logic                       r_dq_oe;
    logic                       r_rwds_o;
    logic                       r_rwds_oe;
    logic                       r_ready;
    logic                       r_valid;
    logic                       r_busy;

    logic [HBUS_ADDR_WIDTH-1:0] w_adr;
    logic [47:0]                w_ca;
    logic                       w_rwds_edge;

    assign w_adr       = bus.hbus_adr_i;
    // Write wins when both request strobes are high, so R/W# is simply ~wrq.
    assign w_ca        = ca_word(~bus.hbus_wrq, 32'(w_adr));
    // The device marks each read byte with an RWDS transition.
    assign w_rwds_edge = bus.hb_rwds_i ^ r_rwds_prev;

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ca        <= '0;
            r_wr        <= 1'b0;
            r_wdat      <= '0;
            r_rdat      <= '0;
            r_lat_dbl   <= 1'b0;
            r_rbyte     <= '0;
            r_got_first <= 1'b0;
            r_rwds_prev <= 1'b0;
            r_ck        <= 1'b0;
            r_cs_n      <= 1'b1;
            r_rst_n     <= 1'b0;
            r_dq_o      <= '0;
            r_dq_oe     <= 1'b0;
            r_rwds_o    <= 1'b0;
            r_rwds_oe   <= 1'b0;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rst_n     <= 1'b1;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_rwds_prev <= bus.hb_rwds_i;

            // CK runs for as long as CS# is low; the RECOVER entry below
            // overrides this with CK low.
            if (r_state != S_IDLE && r_state != S_RECOVER) begin
                r_ck <= ~r_ck;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.hbus_wrq || bus.hbus_rrq) begin
                        r_wr    <= bus.hbus_wrq;
                        r_wdat  <= bus.hbus_dat_i;
                        r_dq_o  <= w_ca[47:40];
                        r_ca    <= {w_ca[39:0], 8'h00};
                        r_dq_oe <= 1'b1;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_CA;
                    end
                end

                S_CA: begin
                    if (r_cnt == 16'd0) begin
                        r_lat_dbl <= bus.hb_rwds_i;
                    end
                    if (r_cnt == 16'd5) begin
                        r_dq_oe <= 1'b0;
                        r_dq_o  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_LAT;
                    end else begin
                        r_dq_o  <= r_ca[47:40];
                        r_ca    <= {r_ca[39:0], 8'h00};
                        r_cnt   <= r_cnt + 16'd1;
                    end
                end

                S_LAT: begin
                    if (r_cnt == (r_lat_dbl ? LAT_LAST_2X : LAT_LAST_1X)) begin
                        r_cnt <= '0;
                        if (r_wr) begin
                            r_dq_oe   <= 1'b1;
                            r_dq_o    <= r_wdat[15:8];
                            r_rwds_oe <= 1'b1;
                            r_rwds_o  <= 1'b0;
                            r_state   <= S_WDATA;
                        end else begin
                            r_got_first <= 1'b0;
                            r_state     <= S_RDATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_WDATA: begin
                    if (r_cnt == 16'd0) begin
                        r_dq_o <= r_wdat[7:0];
                        r_cnt  <= 16'd1;
                    end else begin
                        r_ready   <= 1'b1;
                        r_cs_n    <= 1'b1;
                        r_ck      <= 1'b0;
                        r_dq_oe   <= 1'b0;
                        r_dq_o    <= '0;
                        r_rwds_oe <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_RECOVER;
                    end
                end

                S_RDATA: begin
                    if (w_rwds_edge && r_got_first) begin
                        r_rdat  <= {r_rbyte, bus.hb_dq_i};
                        r_valid <= 1'b1;
                        r_cs_n  <= 1'b1;
                        r_ck    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RECOVER;
                    end else begin
                        if (w_rwds_edge) begin
                            r_rbyte     <= bus.hb_dq_i;
                            r_got_first <= 1'b1;
                        end
`ifdef HBUS_READ_TIMEOUT_EN
                        if (r_cnt == TO_LAST) begin
                            r_rdat  <= 16'hFFFF;
                            r_valid <= 1'b1;
                            r_cs_n  <= 1'b1;
                            r_ck    <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_RECOVER;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
`endif
                    end
                end

                S_RECOVER: begin
                    if (r_cnt == REC_LAST) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hbus_dat_o = r_rdat;
    assign bus.hbus_ready = r_ready;
    assign bus.hbus_valid = r_valid;
    assign bus.hbus_busy  = r_busy;
    assign bus.hb_ck_o    = r_ck;
    assign bus.hb_cs_n_o  = r_cs_n;
    assign bus.hb_rst_n_o = r_rst_n;
    assign bus.hb_rwds_o  = r_rwds_o;
    assign bus.hb_rwds_oe = r_rwds_oe;
    assign bus.hb_dq_o    = r_dq_o;
    assign bus.hb_dq_oe   = r_dq_oe;

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_ctrl
// Directed bench for hyperbus_ctrl: drives requests and a simple device model,
// keeps expected completions in a scoreboard queue and checks pin activity.
// -----------------------------------------------------------------------------
module tb_hyperbus_ctrl;

    logic clk;
    logic rst;

    hyperbus_if #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16)) bus ();

    hyperbus_ctrl #(
        .HBUS_ADDR_WIDTH(32),
        .HBUS_DATA_WIDTH(16),
        .LATENCY(6),
        .CS_HIGH_MIN(2),
        .READ_TIMEOUT(64)
    ) dut (
        .hbus_clk(clk),
        .hbus_rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] dq_log[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cs_cnt = 0;
    int         last_cs_len = 0;
    int         cs_falls = 0;
    int         wdata_pos = -1;
    int         ck_bad = 0;
    logic [1:0] ck_first2 = 2'b00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] pack_log();
        logic [63:0] v = '0;
        foreach (dq_log[i]) v = {v[55:0], dq_log[i]};
        return v;
    endfunction

    // Pin monitor and scoreboard consumer, sampled 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.hb_cs_n_o === 1'b0) begin
            if (cs_cnt == 0) begin
                cs_falls++;
                ck_first2[1] = bus.hb_ck_o;
            end
            if (cs_cnt == 1) ck_first2[0] = bus.hb_ck_o;
            if (bus.hb_rwds_oe === 1'b1 && wdata_pos < 0) wdata_pos = cs_cnt;
            cs_cnt++;
        end else if (cs_cnt != 0) begin
            last_cs_len = cs_cnt;
            cs_cnt = 0;
        end
        if (bus.hb_cs_n_o === 1'b1 && bus.hb_ck_o === 1'b1) ck_bad++;
        if (bus.hb_dq_oe === 1'b1) dq_log.push_back(bus.hb_dq_o);
        if (bus.hbus_ready === 1'b1 || bus.hbus_valid === 1'b1) begin
            check("done_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("done_kind", {bus.hbus_ready, bus.hbus_valid}, {~mon_e.is_rd, mon_e.is_rd});
                if (mon_e.is_rd) check("rd_data", bus.hbus_dat_o, mon_e.data);
            end
        end
    end

    // Issue one request pulse; rwds_hi is presented during the first CA cycle.
    // Returns at the falling edge inside the second CA cycle.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] adr,
                         input logic [15:0] dat, input logic rwds_hi);
        @(negedge clk);
        dq_log.delete();
        wdata_pos      = -1;
        bus.hbus_adr_i = adr;
        bus.hbus_dat_i = dat;
        bus.hbus_rrq   = rd;
        bus.hbus_wrq   = wr;
        bus.hb_rwds_i  = rwds_hi;
        @(negedge clk);
        bus.hbus_rrq   = 1'b0;
        bus.hbus_wrq   = 1'b0;
        @(negedge clk);
        bus.hb_rwds_i  = 1'b0;
    endtask

    // Wait (bounded) for a completion pulse, then check busy over the next cycles.
    task automatic finish_txn(input string tag);
        bit         ok;
        logic [2:0] busy_seq;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.hbus_ready === 1'b1 || bus.hbus_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, ok, 1);
        busy_seq[2] = bus.hbus_busy;
        @(negedge clk);
        busy_seq[1] = bus.hbus_busy;
        @(negedge clk);
        busy_seq[0] = bus.hbus_busy;
        check({tag, "_busy_seq"}, busy_seq, 3'b110);
    endtask

    int falls_before;

    initial begin
        rst            = 1'b1;
        bus.hbus_adr_i = '0;
        bus.hbus_dat_i = '0;
        bus.hbus_rrq   = 1'b0;
        bus.hbus_wrq   = 1'b0;
        bus.hb_rwds_i  = 1'b0;
        bus.hb_dq_i    = '0;
        repeat (3) @(negedge clk);
        check("reset_outs",
              {bus.hb_cs_n_o, bus.hb_ck_o, bus.hb_dq_o, bus.hb_dq_oe, bus.hb_rwds_o, bus.hb_rwds_oe,
               bus.hbus_ready, bus.hbus_valid, bus.hbus_busy, bus.hbus_dat_o},
              {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        check("reset_rst_n", bus.hb_rst_n_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_n_after", bus.hb_rst_n_o, 1);

        // Plain write, normal latency
        exp_q.push_back('{is_rd: 1'b0, data: 16'h0000});
        issue(1'b0, 1'b1, 32'h0000_1234, 16'hA55A, 1'b0);
        finish_txn("wr1");
        check("wr1_cs_len", last_cs_len, 20);
        check("wr1_nbytes", dq_log.size(), 8);
        check("wr1_bytes", pack_log(), 64'h2000_0246_0004_A55A);
        check("wr1_ck_start", ck_first2, 2'b01);
        check("wr1_wdata_pos", wdata_pos, 18);

        // Write with doubled latency
        exp_q.push_back('{is_rd: 1'b0, data: 16'h0000});
        issue(1'b0, 1'b1, 32'h0000_1234, 16'h1357, 1'b1);
        finish_txn("wr2");
        check("wr2_cs_len", last_cs_len, 32);
        check("wr2_bytes", pack_log(), 64'h2000_0246_0004_1357);
        check("wr2_wdata_pos", wdata_pos, 30);

        // Read: device returns 0xBE, 0xEF marked by RWDS transitions
        exp_q.push_back('{is_rd: 1'b1, data: 16'hBEEF});
        issue(1'b1, 1'b0, 32'h0000_0010, 16'h0000, 1'b0);
        repeat (18) @(negedge clk);
        bus.hb_rwds_i = 1'b1;
        bus.hb_dq_i   = 8'hBE;
        @(negedge clk);
        bus.hb_rwds_i = 1'b0;
        bus.hb_dq_i   = 8'hEF;
        finish_txn("rd1");
        bus.hb_dq_i   = 8'h00;
        check("rd1_nbytes", dq_log.size(), 6);
        check("rd1_ca", pack_log(), 64'h0000_A000_0002_0000);
        check("rd1_hold", bus.hbus_dat_o, 16'hBEEF);

        // Simultaneous read+write becomes a write; a request while busy is ignored
        falls_before = cs_falls;
        exp_q.push_back('{is_rd: 1'b0, data: 16'h0000});
        issue(1'b1, 1'b1, 32'h0000_1234, 16'h0F0F, 1'b0);
        repeat (4) @(negedge clk);
        bus.hbus_rrq = 1'b1;
        @(negedge clk);
        bus.hbus_rrq = 1'b0;
        finish_txn("both");
        check("both_bytes", pack_log(), 64'h2000_0246_0004_0F0F);
        repeat (10) @(negedge clk);
        check("busy_req_ignored", cs_falls - falls_before, 1);
        check("rd_hold_after_wr", bus.hbus_dat_o, 16'hBEEF);

        // Reset asserted during latency: no completion expected
        issue(1'b0, 1'b1, 32'h0000_1234, 16'hAAAA, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_lat",
              {bus.hb_cs_n_o, bus.hbus_busy, bus.hb_dq_oe, bus.hb_rwds_oe, bus.hb_ck_o, bus.hb_rst_n_o},
              6'b100000);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_no_pending", exp_q.size(), 0);

        // Write after reset completes normally
        exp_q.push_back('{is_rd: 1'b0, data: 16'h0000});
        issue(1'b0, 1'b1, 32'hFFFF_FFFF, 16'h55AA, 1'b0);
        finish_txn("wr3");
        check("wr3_cs_len", last_cs_len, 20);
        check("wr3_bytes", pack_log(), 64'h3FFF_FFFF_0007_55AA);

`ifdef HBUS_READ_TIMEOUT_EN
        // Read where RWDS never toggles
        exp_q.push_back('{is_rd: 1'b1, data: 16'hFFFF});
        issue(1'b1, 1'b0, 32'h0000_0020, 16'h0000, 1'b0);
        finish_txn("rd_to");
        check("rd_to_cs_len", last_cs_len, 6 + 12 + 64);
        check("rd_to_cs_high", bus.hb_cs_n_o, 1);
`endif

        check("sb_empty", exp_q.size(), 0);
        check("ck_low_when_cs_high", ck_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hyperbus_ctrl.md
# hyperbus_ctrl

HyperBus memory controller that serves the single-word read/write requests issued on the `hbus_*` request interface and drives the external HyperBus pins (CK, CS#, RWDS, DQ[7:0]). It sits between the Wishbone-side request FIFO and the HyperRAM device. It generates the 48-bit command/address phase, counts initial latency (doubling it when the device requests it), moves one 16-bit word, and returns completion on `hbus_ready` or `hbus_valid`.

## Interface
- `HBUS_ADDR_WIDTH`, 32, request address width (16-bit word address)
- `HBUS_DATA_WIDTH`, 16, request data width; fixed at 16
- `LATENCY`, 6, initial latency in CK cycles
- `CS_HIGH_MIN`, 2, minimum CS# high time in `hbus_clk` cycles between transactions
- `READ_TIMEOUT`, 64, read data timeout in `hbus_clk` cycles (used only with `HBUS_READ_TIMEOUT_EN`)

Ports:
- `hbus_clk`  in  1  controller clock; one DQ byte per cycle
- `hbus_rst`  in  1  reset, asynchronous, active-high
- `hbus_adr_i`  in  HBUS_ADDR_WIDTH  request word address
- `hbus_dat_i`  in  16  write data
- `hbus_dat_o`  out  16  read data, valid with `hbus_valid`
- `hbus_rrq`  in  1  read request, single-cycle pulse
- `hbus_wrq`  in  1  write request, single-cycle pulse
- `hbus_ready`  out  1  write-complete pulse
- `hbus_valid`  out  1  read-data pulse
- `hbus_busy`  out  1  transaction in progress
- `hb_ck_o`  out  1  HyperBus CK
- `hb_cs_n_o`  out  1  chip select, active low
- `hb_rst_n_o`  out  1  device reset, active low
- `hb_rwds_i`  in  1  RWDS from device
- `hb_rwds_o`, `hb_rwds_oe`  out  1  RWDS drive and enable
- `hb_dq_i`  in  8  DQ from device
- `hb_dq_o`  out  8  DQ drive
- `hb_dq_oe`  out  1  DQ drive enable

## Operation
- States: IDLE, CA, LAT, WDATA, RDATA, RECOVER.
- **IDLE:** on a cycle with `hbus_wrq` or `hbus_rrq` high, latch address and write data, then go to CA. If both are high, the write wins. Requests outside IDLE are ignored.
- **CA:** 6 cycles. CS# is low and DQ is driven with CA[47:40] first.
  - CA[47] = read (1) / write (0); CA[46] = 0; CA[45] = 1 (linear).
  - CA[44:16] = adr[31:3]; CA[15:3] = 0; CA[2:0] = adr[2:0].
  - `hb_rwds_i` is sampled in the first CA cycle. If it is high, latency is doubled.
- **LAT:** 2*LATENCY cycles, or 4*LATENCY when doubled. DQ is not driven.
- **WDATA:** 2 cycles driving dat[15:8] then dat[7:0]. `hb_rwds_oe`=1 and `hb_rwds_o`=0 (no mask).
- **RDATA:** capture `hb_dq_i` on each cycle where `hb_rwds_i` differs from its value in the previous cycle. The first captured byte goes to [15:8], the second to [7:0]. After the second byte, go to RECOVER.
- **RECOVER:** CS# high and CK low for CS_HIGH_MIN cycles, then IDLE.
- **CK:** low in IDLE and RECOVER. Toggles every cycle while CS# is low, first rising in the second CA cycle.
- `hb_rst_n_o` is low during reset and high afterwards.
- Reset mid-transaction: immediately CS# high, all enables 0, state IDLE. No completion pulse is issued.

## Timing
- Reset values:
  - `hb_cs_n_o`=1
  - `hb_ck_o`=0, `hb_dq_o`=0, `hb_dq_oe`=0, `hb_rwds_o`=0, `hb_rwds_oe`=0
  - `hbus_ready`=0, `hbus_valid`=0, `hbus_busy`=0, `hbus_dat_o`=0
  - `hb_rst_n_o`=0
- All outputs are registered.
- `hbus_busy` rises the cycle after request acceptance and falls on entry to IDLE.
- `hbus_ready` or `hbus_valid` pulses high for exactly 1 cycle, in the first RECOVER cycle. `hbus_dat_o` holds its value until the next read completes.
- Write CS# low duration: 6 + 2*LATENCY + 2 cycles (20 at default), or 6 + 4*LATENCY + 2 (32) when doubled.
- Earliest next acceptance: CS_HIGH_MIN cycles after CS# rises.

## Configuration
- `HBUS_READ_TIMEOUT_EN` defined: RDATA counts cycles. After READ_TIMEOUT cycles without the second byte, go to RECOVER and pulse `hbus_valid` with `hbus_dat_o`=16'hFFFF.
- Not defined: RDATA waits indefinitely for RWDS transitions. No timeout counter is built.

## Test plan
- Write: adr=0x0000_1234, dat=0xA55A, RWDS low in CA, defaults → DQ CA bytes 0x20,0x00,0x02,0x46,0x00,0x04. CS# low 20 cycles, data bytes 0xA5,0x5A, `hbus_ready` pulse 1 cycle, `hbus_busy` cleared 2 cycles later.
- Write with RWDS high in first CA cycle → CS# low 32 cycles. Data timing is shifted by 12 cycles.
- Read: adr=0x10, device toggles RWDS with bytes 0xBE,0xEF after latency → `hbus_valid` pulse with `hbus_dat_o`=0xBEEF. CA[47]=1 (first byte 0xA0).
- `hbus_rrq` and `hbus_wrq` in the same cycle → write transaction. A request pulsed during busy is ignored (no second CS# assertion).
- Reset asserted in LAT → next cycle CS# high, `hbus_busy`=0, no completion pulse. A subsequent write completes normally.
- With `HBUS_READ_TIMEOUT_EN`: read with RWDS never toggling → after 64 RDATA cycles, `hbus_valid` pulse with 0xFFFF and CS# high.
